id_ex_alu_issue: RTL and testbench
==================================

Name: id_ex_alu_issue

Overview:
ID/EX pipeline stage that drives the EX-stage ALU, i.e. the producing end of the ALU's OpCode/A/B/Shift_amt interface.
- Decodes ALUOp/Funct into the 4-bit ALU operation code and selects the B operand.
- Registers the operands, operation code, shift amount, destination register and downstream control bits.
- Honours stall (hold) and flush (bubble) from the hazard unit, and flags jr and illegal R-type functions.

Parameters:
DATA_W, 32, operand/immediate width
REG_W, 5, register-address width

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
Stall  input  1  hold all registered outputs unchanged
Flush  input  1  replace incoming instruction with a bubble
ValidIn  input  1  ID stage holds a real instruction
ALUOp  input  2  main-decoder class: 00 mem/addi, 01 branch, 10 R-type, 11 ori
Funct  input  6  Instruction[5:0]
ShamtIn  input  REG_W  Instruction[10:6]
ReadData1  input  DATA_W  register-file port 1
ReadData2  input  DATA_W  register-file port 2
SignImm  input  DATA_W  sign-/zero-extended immediate
ALUSrc  input  1  1: B = SignImm, 0: B = ReadData2
Rt, Rd  input  REG_W each  destination candidates
RegDst, RegWrite, MemRead, MemWrite, MemtoReg  input  1 each  main-decoder controls
OpCode  output  4  registered ALU operation code
A  output  DATA_W  registered ALU operand A (ReadData1)
B  output  DATA_W  registered ALU operand B
Shift_amt  output  REG_W  registered shift amount
WriteReg  output  REG_W  registered destination (RegDst ? Rd : Rt)
StoreData  output  DATA_W  registered ReadData2 for sw
RegWriteOut, MemReadOut, MemWriteOut, MemtoRegOut  output  1 each  registered controls
ValidOut  output  1  EX holds a real instruction
JumpReg  output  1  registered: EX instruction is jr; target = A
Illegal  output  1  registered: EX instruction is an unsupported R-type funct

Behaviour:
- Reset (rst_n=0 at clock edge): every output cleared to 0; OpCode=0000 (and). Reset overrides Stall and Flush.
- Decode, combinational from ID inputs:
  - ALUOp 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0001 (or).
  - ALUOp 10, by Funct:
    - 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001.
    - 101010 -> 0111 (slt); 000000 -> 0100 (sll); 000010 -> 0101 (srl).
    - 001000 -> 0011 (jr, JumpReg=1).
    - anything else -> 1111 with Illegal=1.
- Shift_amt = ShamtIn when OpCode is 0100/0101, else 0.
- B = ALUSrc ? SignImm : ReadData2. No arithmetic is done here; widths pass through unchanged.
- Register update priority per edge: reset > Flush > Stall > load.
  - Flush: bubble loaded (ValidOut=0, all write/mem controls 0, JumpReg=0, Illegal=0, OpCode=0000, data outputs 0). Flush wins over a simultaneous Stall.
  - Stall (no Flush): every output holds its previous value, including ValidOut.
  - Load: all outputs take decoded/selected values.
- ValidIn=0 on load: load as a bubble (identical to Flush).
- jr loads RegWriteOut=0, MemReadOut=0, MemWriteOut=0, regardless of the corresponding inputs.
- Illegal loads RegWriteOut=0, MemReadOut=0, MemWriteOut=0, with ValidOut=1 so the exception logic sees it.
- Latency: one cycle, from ID inputs sampled at edge N to outputs valid after edge N.
- Reset asserted mid-stall: outputs cleared at the next edge; stall state is not retained.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_JR=0011, ALU_SLL=0100, ALU_SRL=0101, ALU_SUB=0110, ALU_SLT=0111, ALU_ILL=1111).
  - ALUOp class constants.
  - Funct constants.
- Sub-module alu_ctrl_dec: purely combinational ALUOp/Funct -> OpCode, JumpReg, Illegal. It is reused by any future single-cycle variant.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0. Release; ALUOp=10, Funct=100000, ReadData1=5, ReadData2=7, ValidIn=1 -> next cycle OpCode=0010, A=5, B=7, ValidOut=1.
- Shift decode: ALUOp=10, Funct=000000, ShamtIn=4, ReadData2=0x1 -> OpCode=0100, Shift_amt=4, B=0x1. Then Funct=100101, ShamtIn=4 -> OpCode=0001, Shift_amt=0.
- Immediate select: ALUOp=00, ALUSrc=1, SignImm=0xFFFFFFFC, MemRead=1, RegDst=0, Rt=9 -> OpCode=0010, B=0xFFFFFFFC, WriteReg=9, MemReadOut=1.
- Stall/flush: load add, then Stall=1 for 3 cycles with changing inputs -> outputs frozen. Stall=1 with Flush=1 -> bubble (ValidOut=0, RegWriteOut=0).
- jr and illegal:
  - Funct=001000, ReadData1=0x400, RegWrite=1 -> OpCode=0011, JumpReg=1, A=0x400, RegWriteOut=0.
  - Funct=111111 -> OpCode=1111, Illegal=1, RegWriteOut=0, ValidOut=1.
- Reset mid-stall: Stall=1 holding an slt (OpCode=0111), rst_n=0 one cycle -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: ALU opcode, ALUOp class and R-type funct constants shared by the pipeline
package mips_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_JR  = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    localparam logic [1:0] AOP_MEM = 2'b00;
    localparam logic [1:0] AOP_BR  = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;
    localparam logic [1:0] AOP_ORI = 2'b11;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;
endpackage

// File: rtl/id_ex_alu_issue_if.sv
// id_ex_alu_issue_if: ID-side inputs and EX-side ALU/control outputs of the ID/EX stage
interface id_ex_alu_issue_if #(parameter int DATA_W = 32, parameter int REG_W = 5);
    logic              Stall, Flush, ValidIn;
    logic [1:0]        ALUOp;
    logic [5:0]        Funct;
    logic [REG_W-1:0]  ShamtIn, Rt, Rd;
    logic [DATA_W-1:0] ReadData1, ReadData2, SignImm;
    logic              ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg;
    logic [3:0]        OpCode;
    logic [DATA_W-1:0] A, B, StoreData;
    logic [REG_W-1:0]  Shift_amt, WriteReg;
    logic              RegWriteOut, MemReadOut, MemWriteOut, MemtoRegOut;
    logic              ValidOut, JumpReg, Illegal;

    modport master (
        output Stall, Flush, ValidIn, ALUOp, Funct, ShamtIn, Rt, Rd, ReadData1, ReadData2, SignImm,
               ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg,
        input  OpCode, A, B, StoreData, Shift_amt, WriteReg, RegWriteOut, MemReadOut, MemWriteOut,
               MemtoRegOut, ValidOut, JumpReg, Illegal
    );
    modport slave (
        input  Stall, Flush, ValidIn, ALUOp, Funct, ShamtIn, Rt, Rd, ReadData1, ReadData2, SignImm,
               ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg,
        output OpCode, A, B, StoreData, Shift_amt, WriteReg, RegWriteOut, MemReadOut, MemWriteOut,
               MemtoRegOut, ValidOut, JumpReg, Illegal
    );
endinterface

// File: rtl/id_ex_alu_issue_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALUOp/Funct to ALU opcode, jr and illegal-funct decode
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] op_code,
    output logic       jump_reg,
    output logic       illegal
);
    logic [3:0] r_op;
    always_comb begin
        r_op = funct == F_ADD ? ALU_ADD :
               funct == F_SUB ? ALU_SUB :
               funct == F_AND ? ALU_AND :
               funct == F_OR  ? ALU_OR  :
               funct == F_SLT ? ALU_SLT :
               funct == F_SLL ? ALU_SLL :
               funct == F_SRL ? ALU_SRL :
               funct == F_JR  ? ALU_JR  : ALU_ILL;
        op_code = alu_op == AOP_MEM ? ALU_ADD :
                  alu_op == AOP_BR  ? ALU_SUB :
                  alu_op == AOP_ORI ? ALU_OR  : r_op;
        jump_reg = alu_op == AOP_R && r_op == ALU_JR;
        illegal  = alu_op == AOP_R && r_op == ALU_ILL;
    end
endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX register feeding the EX ALU with stall, flush and bubble handling
module id_ex_alu_issue
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input logic              clk,
    input logic              rst_n,
    id_ex_alu_issue_if.slave bus
);
    logic [3:0]        op;
    logic              jr, ill;
    logic [DATA_W-1:0] b_sel;
    logic [REG_W-1:0]  sh_sel;

    alu_ctrl_dec u_dec (.alu_op(bus.ALUOp), .funct(bus.Funct), .op_code(op), .jump_reg(jr), .illegal(ill));

    always_comb begin
        b_sel  = bus.ALUSrc ? bus.SignImm : bus.ReadData2;
        sh_sel = (op == ALU_SLL || op == ALU_SRL) ? bus.ShamtIn : '0;
    end

    // jr and illegal instructions must never write state downstream
    always_ff @(posedge clk) begin
        if (!rst_n || bus.Flush || (!bus.Stall && !bus.ValidIn)) begin
            bus.OpCode      <= ALU_AND;
            bus.A           <= '0;
            bus.B           <= '0;
            bus.Shift_amt   <= '0;
            bus.WriteReg    <= '0;
            bus.StoreData   <= '0;
            bus.RegWriteOut <= 1'b0;
            bus.MemReadOut  <= 1'b0;
            bus.MemWriteOut <= 1'b0;
            bus.MemtoRegOut <= 1'b0;
            bus.ValidOut    <= 1'b0;
            bus.JumpReg     <= 1'b0;
            bus.Illegal     <= 1'b0;
        end else if (!bus.Stall) begin
            bus.OpCode      <= op;
            bus.A           <= bus.ReadData1;
            bus.B           <= b_sel;
            bus.Shift_amt   <= sh_sel;
            bus.WriteReg    <= bus.RegDst ? bus.Rd : bus.Rt;
            bus.StoreData   <= bus.ReadData2;
            bus.RegWriteOut <= bus.RegWrite && !(jr || ill);
            bus.MemReadOut  <= bus.MemRead && !(jr || ill);
            bus.MemWriteOut <= bus.MemWrite && !(jr || ill);
            bus.MemtoRegOut <= bus.MemtoReg;
            bus.ValidOut    <= 1'b1;
            bus.JumpReg     <= jr;
            bus.Illegal     <= ill;
        end
    end
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue: directed vector table plus randomized run against a reference model
module tb_id_ex_alu_issue;
    typedef struct packed {
        logic        rst_n, Stall, Flush, ValidIn;
        logic [1:0]  ALUOp;
        logic [5:0]  Funct;
        logic [4:0]  ShamtIn;
        logic [31:0] rd1, rd2, imm;
        logic        ALUSrc;
        logic [4:0]  Rt, Rd;
        logic        RegDst, RegWrite, MemRead, MemWrite, MemtoReg;
    } in_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh, wr;
        logic [31:0] sd;
        logic        rw, mr, mw, m2r, v, jr, ill;
    } out_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh, wr;
        logic        rw, mr, v, jr, ill;
    } chk_t;

    typedef struct packed {
        in_t  i;
        chk_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    out_t mdl = '0;
    vec_t tbl[$];

    id_ex_alu_issue_if #(.DATA_W(32), .REG_W(5)) bus ();
    id_ex_alu_issue #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic out_t ref_load(in_t v);
        out_t o;
        logic [3:0] op;
        case (v.ALUOp)
            2'd0: op = 4'd2;
            2'd1: op = 4'd6;
            2'd3: op = 4'd1;
            default:
                case (v.Funct)
                    6'd32: op = 4'd2;
                    6'd34: op = 4'd6;
                    6'd36: op = 4'd0;
                    6'd37: op = 4'd1;
                    6'd42: op = 4'd7;
                    6'd0:  op = 4'd4;
                    6'd2:  op = 4'd5;
                    6'd8:  op = 4'd3;
                    default: op = 4'd15;
                endcase
        endcase
        o.op  = op;
        o.jr  = v.ALUOp == 2'd2 && v.Funct == 6'd8;
        o.ill = op == 4'd15;
        o.a   = v.rd1;
        o.b   = v.ALUSrc ? v.imm : v.rd2;
        o.sh  = (op == 4'd4 || op == 4'd5) ? v.ShamtIn : 5'd0;
        o.wr  = v.RegDst ? v.Rd : v.Rt;
        o.sd  = v.rd2;
        o.rw  = v.RegWrite & ~o.jr & ~o.ill;
        o.mr  = v.MemRead & ~o.jr & ~o.ill;
        o.mw  = v.MemWrite & ~o.jr & ~o.ill;
        o.m2r = v.MemtoReg;
        o.v   = 1'b1;
        return o;
    endfunction

    function automatic out_t dut_out();
        return '{bus.OpCode, bus.A, bus.B, bus.Shift_amt, bus.WriteReg, bus.StoreData, bus.RegWriteOut,
                 bus.MemReadOut, bus.MemWriteOut, bus.MemtoRegOut, bus.ValidOut, bus.JumpReg, bus.Illegal};
    endfunction

    function automatic chk_t to_chk(out_t o);
        return '{o.op, o.a, o.b, o.sh, o.wr, o.rw, o.mr, o.v, o.jr, o.ill};
    endfunction

    task automatic apply(input in_t v);
        rst_n         = v.rst_n;
        bus.Stall     = v.Stall;
        bus.Flush     = v.Flush;
        bus.ValidIn   = v.ValidIn;
        bus.ALUOp     = v.ALUOp;
        bus.Funct     = v.Funct;
        bus.ShamtIn   = v.ShamtIn;
        bus.ReadData1 = v.rd1;
        bus.ReadData2 = v.rd2;
        bus.SignImm   = v.imm;
        bus.ALUSrc    = v.ALUSrc;
        bus.Rt        = v.Rt;
        bus.Rd        = v.Rd;
        bus.RegDst    = v.RegDst;
        bus.RegWrite  = v.RegWrite;
        bus.MemRead   = v.MemRead;
        bus.MemWrite  = v.MemWrite;
        bus.MemtoReg  = v.MemtoReg;
        @(posedge clk);
        #1;
        if (!v.rst_n || v.Flush) mdl = '0;
        else if (!v.Stall) mdl = v.ValidIn ? ref_load(v) : '0;
        total++;
        if (dut_out() !== mdl) begin
            bad++;
            $display("FAIL model: got %h want %h", dut_out(), mdl);
        end
    endtask

    function automatic in_t rnd_in();
        in_t v;
        logic [5:0] fl [10] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd2, 6'd8, 6'd63, 6'd17};
        v = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        v.Funct = $urandom_range(0, 4) == 0 ? 6'($urandom) : fl[$urandom_range(0, 9)];
        v.rst_n = $urandom_range(0, 29) != 0;
        v.Stall = $urandom_range(0, 4) == 0;
        v.Flush = $urandom_range(0, 9) == 0;
        v.ValidIn = $urandom_range(0, 6) != 0;
        return v;
    endfunction

    function automatic void add(in_t i, chk_t e);
        tbl.push_back('{i, e});
    endfunction

    initial begin
        in_t b, v;
        b = '0;
        b.rst_n = 1; b.ValidIn = 1; b.ALUOp = 2'd2; b.Funct = 6'd32;
        b.RegDst = 1; b.Rd = 5'd3; b.Rt = 5'd9; b.RegWrite = 1;
        for (int k = 0; k < 2; k++) begin
            v = rnd_in(); v.rst_n = 0;
            add(v, '0);
        end
        v = b; v.rd1 = 5; v.rd2 = 7;
        add(v, '{4'h2, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        v = b; v.Funct = 6'd0; v.ShamtIn = 5'd4; v.rd2 = 1;
        add(v, '{4'h4, 32'd0, 32'd1, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        v = b; v.Funct = 6'd37; v.ShamtIn = 5'd4; v.rd2 = 1;
        add(v, '{4'h1, 32'd0, 32'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        v = b; v.ALUOp = 2'd0; v.ALUSrc = 1; v.imm = 32'hFFFF_FFFC; v.MemRead = 1; v.RegDst = 0; v.MemtoReg = 1; v.rd2 = 1;
        add(v, '{4'h2, 32'd0, 32'hFFFF_FFFC, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        v = b; v.rd1 = 5; v.rd2 = 7;
        add(v, '{4'h2, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            v = b; v.Stall = 1; v.Funct = 6'd34; v.rd1 = 32'(100 + k); v.rd2 = 32'(k); v.ValidIn = k[0];
            add(v, '{4'h2, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        v = b; v.Stall = 1; v.Flush = 1;
        add(v, '0);
        v = b; v.Funct = 6'd8; v.rd1 = 32'h400; v.MemRead = 1; v.MemWrite = 1;
        add(v, '{4'h3, 32'h400, 32'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        v = b; v.Funct = 6'd63; v.MemRead = 1;
        add(v, '{4'hF, 32'd0, 32'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        v = b; v.ValidIn = 0; v.rd1 = 32'h55;
        add(v, '0);
        v = b; v.ALUOp = 2'd1; v.RegWrite = 0; v.rd1 = 9; v.rd2 = 9;
        add(v, '{4'h6, 32'd9, 32'd9, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        v = b; v.ALUOp = 2'd3; v.ALUSrc = 1; v.imm = 32'hFF;
        add(v, '{4'h1, 32'd0, 32'hFF, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        v = b; v.Funct = 6'd42; v.rd1 = 1; v.rd2 = 2;
        add(v, '{4'h7, 32'd1, 32'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        v = b; v.Stall = 1; v.Funct = 6'd2; v.rd1 = 77;
        add(v, '{4'h7, 32'd1, 32'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        v = b; v.Stall = 1; v.rst_n = 0;
        add(v, '0);

        foreach (tbl[n]) begin
            apply(tbl[n].i);
            total++;
            if (to_chk(dut_out()) !== tbl[n].e) begin
                bad++;
                $display("FAIL vec%0d: got %h want %h", n, to_chk(dut_out()), tbl[n].e);
            end
        end
        for (int k = 0; k < 400; k++) apply(rnd_in());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
